morse_decoder: RTL and testbench

//  Receive side of the lab's 8-letter Morse link (letters S..Z, 3-bit code). Samples a serial

---
 rtl/morse_pkg.sv | 51 +++++
 rtl/morse_decoder_tick_gen.sv | 37 +++
 rtl/morse_decoder.sv | 173 +++++++++++++++++
 tb/tb_morse_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions for the S..Z link: code table, letter codes and decoder state encoding.
// The pattern table is also used by the transmitter LUT, so edit both sides together.
package morse_pkg;

    localparam int MORSE_W = 16;

    localparam logic [2:0] CODE_S = 3'd0;
    localparam logic [2:0] CODE_T = 3'd1;
    localparam logic [2:0] CODE_U = 3'd2;
    localparam logic [2:0] CODE_V = 3'd3;
    localparam logic [2:0] CODE_W = 3'd4;
    localparam logic [2:0] CODE_X = 3'd5;
    localparam logic [2:0] CODE_Y = 3'd6;
    localparam logic [2:0] CODE_Z = 3'd7;

    // Left-aligned patterns, index = letter code; trailing gap zeros are part of the compare.
    localparam logic [0:7][MORSE_W-1:0] MORSE_TABLE = {
        16'b1010100000000000,
        16'b1110000000000000,
        16'b1010111000000000,
        16'b1010101110000000,
        16'b1011101110000000,
        16'b1110101011100000,
        16'b1110101110111000,
        16'b1110111010100000
    };

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RECV  = 2'd1;
    localparam state_t DRAIN = 2'd2;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } match_t;

    function automatic match_t match_pattern(input logic [MORSE_W-1:0] pat);
        match_t m;
        m.hit  = 1'b0;
        m.code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pat == MORSE_TABLE[i]) begin
                m.hit  = 1'b1;
                m.code = 3'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/morse_decoder_tick_gen.sv
// Symbol-rate tick: down-counter that fires on zero and reloads TICK_DIV-1.
// align_i forces a half-period reload so later ticks land mid-bit.
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic align_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(TICK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (align_i) begin
            cnt_d = HALF;
        end else if (tick_o) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes line_in, samples once per tick, decodes S..Z or flags err.
// Optional MORSE_DEC_PHASE_ALIGN_EN: realign the tick to mid-bit on the first rising edge in IDLE.
//
// state | meaning
// IDLE  | waiting for the first 1 of a letter
// RECV  | collecting bits until GAP_ZEROS consecutive zeros
// DRAIN | overflowed; swallowing input until a clean gap
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_ZEROS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       err,
    output logic       busy
);

    localparam int ZW = $clog2(GAP_ZEROS + 1);

    logic               sync1_q, sync2_q;
    logic               tick, align, step;
    state_t             state_q, state_d;
    logic [MORSE_W-1:0] buf_q, buf_d;
    logic [4:0]         idx_q, idx_d;
    logic [ZW-1:0]      zcnt_q, zcnt_d, zcnt_inc;
    logic               gap_hit;
    logic [2:0]         letter_q, letter_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    match_t             m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef MORSE_DEC_PHASE_ALIGN_EN
    logic line_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_prev_q <= 1'b0;
        end else begin
            line_prev_q <= sync2_q;
        end
    end

    assign align = (state_q == IDLE) && sync2_q && !line_prev_q;
`else
    assign align = 1'b0;
`endif

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .align_i (align),
        .tick_o  (tick)
    );

    // The realigning edge cycle is not a sample; the first 1 is taken on the mid-bit tick.
    assign step = tick && !align;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        zcnt_d   = zcnt_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        zcnt_inc = zcnt_q + ZW'(1);
        gap_hit  = (zcnt_inc == ZW'(GAP_ZEROS));
        m        = match_pattern(buf_q);

        if (step) begin
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        buf_d   = {1'b1, {(MORSE_W-1){1'b0}}};
                        idx_d   = 5'd1;
                        zcnt_d  = '0;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (sync2_q) begin
                        zcnt_d = '0;
                        if (idx_q == 5'd16) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            buf_d[4'd15 - idx_q[3:0]] = 1'b1;
                            idx_d = idx_q + 5'd1;
                        end
                    end else begin
                        // Stored zeros leave buf_q unchanged, so it already holds the final pattern.
                        if (idx_q < 5'd16) begin
                            idx_d = idx_q + 5'd1;
                        end
                        zcnt_d = zcnt_inc;
                        if (gap_hit) begin
                            if (m.hit) begin
                                valid_d  = 1'b1;
                                letter_d = m.code;
                            end else begin
                                err_d = 1'b1;
                            end
                            buf_d   = '0;
                            idx_d   = '0;
                            zcnt_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (sync2_q) begin
                        zcnt_d = '0;
                    end else begin
                        zcnt_d = zcnt_inc;
                        if (gap_hit) begin
                            buf_d   = '0;
                            idx_d   = '0;
                            zcnt_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    buf_d   = '0;
                    idx_d   = '0;
                    zcnt_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            idx_q    <= '0;
            zcnt_q   <= '0;
            letter_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            zcnt_q   <= zcnt_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder (default build): string-level reference model plus literal spot checks.
module tb_morse_decoder;

    localparam int D   = 4;
    localparam int GAP = 3;

    logic       clk;
    logic       rst_n;
    logic       line_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    morse_decoder #(.TICK_DIV(D), .GAP_ZEROS(GAP)) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .line_in      (line_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .err          (err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Letters as dot/dash strings, trailing zeros stripped; index = letter code.
    string tbl[8] = '{"10101", "111", "1010111", "101010111",
                      "101110111", "11101010111", "1110101110111", "11101110101"};

    // Reference model state
    int         k = 0;
    bit         hist[$];
    bit         m_active = 0;
    bit         m_drain  = 0;
    string      m_bits   = "";
    int         m_zrun   = 0;
    bit         exp_valid = 0;
    bit         exp_err   = 0;
    bit         exp_busy  = 0;
    logic [2:0] exp_letter = 3'd0;

    // Observed pulses
    int obs_valid = 0;
    int obs_err   = 0;
    int obs_letters[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit s);
        string t;
        bit    found;
        if (!m_active) begin
            if (s) begin
                m_active = 1;
                m_drain  = 0;
                m_bits   = "1";
                m_zrun   = 0;
            end
        end else if (m_drain) begin
            if (s) m_zrun = 0;
            else   m_zrun++;
            if (m_zrun == GAP) begin
                m_active = 0;
                m_drain  = 0;
            end
        end else if (s) begin
            m_zrun = 0;
            if (m_bits.len() == 16) begin
                exp_err = 1;
                m_drain = 1;
            end else begin
                m_bits = {m_bits, "1"};
            end
        end else begin
            if (m_bits.len() < 16) m_bits = {m_bits, "0"};
            m_zrun++;
            if (m_zrun == GAP) begin
                t = m_bits;
                while (t.len() > 1 && t[t.len()-1] == "0") t = t.substr(0, t.len() - 2);
                found = 0;
                for (int i = 0; i < 8; i++) begin
                    if (t == tbl[i]) begin
                        found      = 1;
                        exp_letter = 3'(i);
                    end
                end
                if (found) exp_valid = 1;
                else       exp_err   = 1;
                m_active = 0;
                m_zrun   = 0;
            end
        end
    endtask

    // Tick fires on posedges j with j % D == D-1 after reset release; sample is the line two edges back.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            hist.delete();
            m_active = 0; m_drain = 0; m_bits = ""; m_zrun = 0;
            exp_valid = 0; exp_err = 0; exp_busy = 0; exp_letter = 3'd0;
        end else begin
            bit s;
            s = (k >= 2) ? hist[k-2] : 1'b0;
            hist.push_back(line_in);
            exp_valid = 0;
            exp_err   = 0;
            if (k % D == D - 1) model_step(s);
            exp_busy = m_active;
            k++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("letter", 32'(letter), 32'(exp_letter));
            chk("letter_valid", 32'(letter_valid), 32'(exp_valid));
            chk("err", 32'(err), 32'(exp_err));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (letter_valid === 1'b1) begin
                obs_valid++;
                obs_letters.push_back(int'(letter));
            end
            if (err === 1'b1) obs_err++;
        end
    end

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            line_in = (s[i] == "1");
            repeat (D) @(negedge clk);
        end
    endtask

    task automatic settle();
        line_in = 1'b0;
        repeat (3 * D) @(negedge clk);
        #2;
    endtask

    int    v0, e0, last;
    string junk, c;

    initial begin
        rst_n   = 1'b1;
        line_in = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_letter", 32'(letter), 0);
        chk("rst_valid", 32'(letter_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);

        // T
        v0 = obs_valid; e0 = obs_err;
        send_str("111000");
        settle();
        chk("T_valid_cnt", 32'(obs_valid - v0), 1);
        chk("T_letter", 32'(obs_letters[$]), 1);
        chk("T_err_cnt", 32'(obs_err - e0), 0);
        chk("T_busy", 32'(busy), 0);

        // Y
        v0 = obs_valid;
        send_str("1110101110111000");
        settle();
        chk("Y_valid_cnt", 32'(obs_valid - v0), 1);
        chk("Y_letter", 32'(obs_letters[$]), 6);

        // No match: error, letter holds Y
        v0 = obs_valid; e0 = obs_err;
        send_str("1101000");
        settle();
        chk("nm_err_cnt", 32'(obs_err - e0), 1);
        chk("nm_valid_cnt", 32'(obs_valid - v0), 0);
        chk("nm_letter_hold", 32'(letter), 6);

        // Overflow: 20 ones then zeros
        v0 = obs_valid; e0 = obs_err;
        send_str("11111111111111111111");
        chk("ovf_busy_drain", 32'(busy), 1);
        chk("ovf_err_mid", 32'(obs_err - e0), 1);
        send_str("000");
        settle();
        chk("ovf_err_cnt", 32'(obs_err - e0), 1);
        chk("ovf_valid_cnt", 32'(obs_valid - v0), 0);
        chk("ovf_busy_end", 32'(busy), 0);
        chk("ovf_letter_hold", 32'(letter), 6);

        // Reset in the middle of V
        v0 = obs_valid; e0 = obs_err;
        send_str("10101");
        chk("V_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_letter", 32'(letter), 0);
        chk("rstmid_valid", 32'(letter_valid), 0);
        chk("rstmid_err", 32'(err), 0);
        chk("rstmid_busy", 32'(busy), 0);
        line_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_str("1010111000");
        settle();
        chk("rstmid_no_err", 32'(obs_err - e0), 0);
        chk("U_valid_cnt", 32'(obs_valid - v0), 1);
        chk("U_letter", 32'(obs_letters[$]), 2);

        // Z then S back to back
        v0 = obs_valid;
        send_str("11101110101000");
        send_str("10101000");
        settle();
        chk("ZS_valid_cnt", 32'(obs_valid - v0), 2);
        last = obs_letters.size();
        chk("ZS_first", 32'(obs_letters[last-2]), 7);
        chk("ZS_second", 32'(obs_letters[last-1]), 0);

        // Randomized letters and junk patterns with random gaps
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                send_str(tbl[$urandom_range(0, 7)]);
            end else begin
                junk = "1";
                for (int b = $urandom_range(0, 17); b > 0; b--) begin
                    c = ($urandom_range(0, 1) != 0) ? "1" : "0";
                    junk = {junk, c};
                end
                send_str(junk);
            end
            line_in = 1'b0;
            repeat ($urandom_range(GAP, GAP + 3) * D + $urandom_range(0, 2)) @(negedge clk);
        end
        settle();
        chk("end_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
